sram_d_arbiter: RTL
===================

# sram_d_arbiter

Round-robin OBI arbiter that shares the data port of the 48 kB SRAM wrapper between NUM_REQ data masters (core LSU, DMA, Wishbone bridge). Sits directly in front of the wrapper's `sram_d_*` port. It performs the address-range check the wrapper does not. It tracks the single in-flight transaction so that each read/write response is returned only to the master that issued it.

## Interface
Parameters:
- NUM_REQ, 2: number of upstream masters (2..4); index 0 is highest priority after reset.
- SRAM_BASE_ADDR, 32'h8000_0000: first legal byte address.
- SRAM_END_ADDR, 32'h8000_C000: first illegal byte address above the SRAM (exclusive bound).
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned for out-of-range accesses.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- m_req_i  in  NUM_REQ  per-master OBI request.
- m_gnt_o  out  NUM_REQ  per-master grant, one-hot or zero.
- m_addr_i  in  NUM_REQ*32  per-master byte address; master k occupies bits [32k+31:32k].
- m_we_i  in  NUM_REQ  per-master write enable.
- m_be_i  in  NUM_REQ*4  per-master byte enables.
- m_wdata_i  in  NUM_REQ*32  per-master write data.
- m_rvalid_o  out  NUM_REQ  per-master response valid, one-hot or zero.
- m_rdata_o  out  32  response data, shared and qualified by m_rvalid_o.
- m_err_o  out  NUM_REQ  per-master error, asserted with rvalid for an out-of-range access.
- sram_req_o  out  1  downstream OBI request.
- sram_gnt_i  in  1  downstream grant.
- sram_addr_o  out  32  downstream address.
- sram_we_o  out  1  downstream write enable.
- sram_be_o  out  4  downstream byte enables.
- sram_wdata_o  out  32  downstream write data.
- sram_rvalid_i  in  1  downstream response valid, one cycle after the downstream grant.
- sram_rdata_i  in  32  downstream read data.
- contention_cnt_o  out  16  saturating count of cycles in which 2 or more masters request.

## Operation
- Arbitration is combinational each cycle among the masters with m_req_i=1.
  - The search starts at rr_ptr_q and wraps modulo NUM_REQ.
  - The first requester found is the winner w.
- Legal access (SRAM_BASE_ADDR <= addr < SRAM_END_ADDR):
  - Forward w's addr/we/be/wdata to sram_*, with sram_req_o=1.
  - Assert m_gnt_o[w] = sram_gnt_i.
- Illegal access:
  - sram_req_o=0.
  - m_gnt_o[w]=1 unconditionally.
  - Set the error flag for the response.
- Downstream fields are driven from the winner even when the request is illegal. They are don't-care when sram_req_o=0 but must not be X.
- On any granted handshake (m_gnt_o[w]=1), capture into the response register:
  - resp_vld_q=1
  - resp_id_q=w
  - resp_err_q=illegal
  - rr_ptr_q=(w+1) mod NUM_REQ
- When no handshake occurs, rr_ptr_q holds and resp_vld_q is cleared.
- Response routing:
  - Legal response: m_rvalid_o[resp_id_q] = resp_vld_q & sram_rvalid_i, and m_rdata_o = sram_rdata_i.
  - Error response: m_rvalid_o[resp_id_q] = resp_vld_q, m_err_o[resp_id_q]=1, and m_rdata_o = ERR_RDATA.
- Writes also receive a response (rvalid, rdata don't-care unless error).
- sram_rvalid_i arriving with resp_vld_q=0, or with resp_err_q=1, is dropped.
- contention_cnt_o increments when popcount(m_req_i) >= 2 and saturates at 16'hFFFF.
- Masters hold req/addr/we/be/wdata stable until gnt (OBI rule). The arbiter does not latch request fields.

## Timing
- Grant: combinational, same cycle as the request (zero added latency).
- Response: exactly 1 cycle after the grant, for both legal and illegal accesses.
- Throughput: one granted transaction per cycle, back-to-back, with masters alternating under contention.
- Pipelining: a new grant in cycle N+1 coexists with the response of the cycle-N grant.
- Reset (rst_ni=0 at a rising edge) sets rr_ptr_q=0, resp_vld_q=0, resp_id_q=0, resp_err_q=0 and contention_cnt_o=0.
- Output values while rst_ni=0:
  - m_rvalid_o=0 and m_err_o=0 from the next cycle.
  - m_gnt_o, sram_req_o and m_rdata_o follow the combinational rules.
- Reset mid-transaction: the pending response is discarded, and a downstream rvalid in the cycle after reset is dropped.
- Boundaries:
  - addr = SRAM_END_ADDR-4 is legal; addr = SRAM_END_ADDR is illegal; addr = SRAM_BASE_ADDR-1 is illegal.
- Pointer wrap: a winner at NUM_REQ-1 sets rr_ptr_q=0.
- sram_gnt_i=0 with a legal winner:
  - No grant is issued and the pointer holds.
  - The same master is re-offered next cycle. No other master is granted in that cycle.

## Test plan
- Master 0 reads 32'h8000_0010 alone, SRAM returns 32'h1234_5678 → m_gnt_o=01 in cycle 0; m_rvalid_o=01, m_rdata_o=32'h1234_5678, m_err_o=0 in cycle 1.
- Both masters request continuously for 6 cycles after reset → grants 0,1,0,1,0,1; each rvalid lands on the matching master 1 cycle later; contention_cnt_o=6.
- Master 1 writes 32'h8000_C000, then reads 32'h8000_BFFC → first access: sram_req_o=0, then m_err_o[1]=1 with rdata 32'hDEAD_BEEF. Second access: forwarded, m_err_o=0.
- Master 0 makes an illegal access while master 1 is legal in the next cycle → responses return in order: error to master 0, SRAM data to master 1, with no crossover.
- sram_gnt_i held 0 for 3 cycles with both requesting → m_gnt_o=00 and rr_ptr_q unchanged; on release, the master at rr_ptr_q is granted first.
- rst_ni low in the cycle after a grant → no m_rvalid_o at any master; after release, a master-0 request is granted first, and contention_cnt_o restarts from 0.

Source files
------------

// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter
//
// Round-robin OBI arbiter in front of the data port of the 48 kB SRAM
// wrapper. Up to four data masters (core LSU, DMA, Wishbone bridge) share
// the port. The arbiter rejects accesses outside the SRAM window and answers
// them locally with an error response. It remembers which master owns the
// single in-flight transaction, so each response goes back only to that master.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           synchronous active-low reset
//   m_req_i          per-master request
//   m_gnt_o          per-master grant (one-hot or zero)
//   m_addr_i         per-master byte address, master k at [32k+31:32k]
//   m_we_i           per-master write enable
//   m_be_i           per-master byte enables, master k at [4k+3:4k]
//   m_wdata_i        per-master write data, master k at [32k+31:32k]
//   m_rvalid_o       per-master response valid (one-hot or zero)
//   m_rdata_o        shared response data, qualified by m_rvalid_o
//   m_err_o          per-master error flag, raised with rvalid for bad addresses
//   sram_req_o       downstream request
//   sram_gnt_i       downstream grant
//   sram_addr_o      downstream address
//   sram_we_o        downstream write enable
//   sram_be_o        downstream byte enables
//   sram_wdata_o     downstream write data
//   sram_rvalid_i    downstream response valid, one cycle after the grant
//   sram_rdata_i     downstream read data
//   contention_cnt_o saturating count of cycles with two or more requesters

module sram_d_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      m_req_i,
  output logic [NUM_REQ-1:0]      m_gnt_o,
  input  logic [NUM_REQ*32-1:0]   m_addr_i,
  input  logic [NUM_REQ-1:0]      m_we_i,
  input  logic [NUM_REQ*4-1:0]    m_be_i,
  input  logic [NUM_REQ*32-1:0]   m_wdata_i,
  output logic [NUM_REQ-1:0]      m_rvalid_o,
  output logic [31:0]             m_rdata_o,
  output logic [NUM_REQ-1:0]      m_err_o,
  output logic                    sram_req_o,
  input  logic                    sram_gnt_i,
  output logic [31:0]             sram_addr_o,
  output logic                    sram_we_o,
  output logic [3:0]              sram_be_o,
  output logic [31:0]             sram_wdata_o,
  input  logic                    sram_rvalid_i,
  input  logic [31:0]             sram_rdata_i,
  output logic [15:0]             contention_cnt_o
);

  localparam int unsigned IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDW-1:0] idx_t;

  idx_t        rr_ptr_q;
  idx_t        resp_id_q;
  logic        resp_vld_q;
  logic        resp_err_q;
  logic [15:0] contention_cnt_q;

  idx_t        winner;
  idx_t        next_ptr;
  logic        any_req;
  logic        legal;
  logic        handshake;
  logic        contention;
  int unsigned req_cnt;
  logic [31:0] win_addr;
  logic        win_we;
  logic [3:0]  win_be;
  logic [31:0] win_wdata;
  logic        resp_fire;
  logic        resp_is_err;

  // Rotate a master index by an offset, wrapping modulo NUM_REQ.
  function automatic idx_t rr_index(input idx_t base, input int unsigned off);
    int unsigned s;
    s = {{(32-IDW){1'b0}}, base} + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  // Round-robin search starting at rr_ptr_q; the first requester wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_req && m_req_i[rr_index(rr_ptr_q, i)]) begin
        any_req = 1'b1;
        winner  = rr_index(rr_ptr_q, i);
      end
    end
  end

  // Winner's request fields. Master 0 is the fallback when nobody requests,
  // so the downstream bus never carries X.
  always_comb begin
    win_addr  = m_addr_i[31:0];
    win_we    = m_we_i[0];
    win_be    = m_be_i[3:0];
    win_wdata = m_wdata_i[31:0];
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == idx_t'(k)) begin
        win_addr  = m_addr_i[32*k +: 32];
        win_we    = m_we_i[k];
        win_be    = m_be_i[4*k +: 4];
        win_wdata = m_wdata_i[32*k +: 32];
      end
    end
  end

  assign legal = (win_addr >= SRAM_BASE_ADDR) && (win_addr < SRAM_END_ADDR);

  // Illegal accesses never reach the SRAM, so they are granted at once and
  // answered by the arbiter itself one cycle later.
  assign handshake = any_req & (~legal | sram_gnt_i);

  assign sram_req_o   = any_req & legal;
  assign sram_addr_o  = win_addr;
  assign sram_we_o    = win_we;
  assign sram_be_o    = win_be;
  assign sram_wdata_o = win_wdata;

  always_comb begin
    m_gnt_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (handshake && winner == idx_t'(k)) m_gnt_o[k] = 1'b1;
    end
  end

  always_comb begin
    req_cnt = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (m_req_i[k]) req_cnt++;
    end
  end

  assign contention = (req_cnt >= 2);
  assign next_ptr   = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);

  // Response register and round-robin pointer. A stalled legal request
  // leaves the pointer alone so the same master is offered again.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q         <= '0;
      resp_vld_q       <= 1'b0;
      resp_id_q        <= '0;
      resp_err_q       <= 1'b0;
      contention_cnt_q <= '0;
    end else begin
      resp_vld_q <= handshake;
      if (handshake) begin
        resp_id_q  <= winner;
        resp_err_q <= ~legal;
        rr_ptr_q   <= next_ptr;
      end
      if (contention && contention_cnt_q != 16'hFFFF) begin
        contention_cnt_q <= contention_cnt_q + 16'd1;
      end
    end
  end

  assign contention_cnt_o = contention_cnt_q;

  // Error responses ignore the SRAM entirely; a stray sram_rvalid_i with no
  // legal transaction pending is dropped.
  assign resp_is_err = resp_vld_q & resp_err_q;
  assign resp_fire   = resp_vld_q & (resp_err_q | sram_rvalid_i);

  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (resp_id_q == idx_t'(k)) begin
        m_rvalid_o[k] = resp_fire;
        m_err_o[k]    = resp_is_err;
      end
    end
  end

  assign m_rdata_o = resp_is_err ? ERR_RDATA : sram_rdata_i;

endmodule
